// File: rtl/random_state_scheduler.sv
// Two-state random-duration scheduler: alternates o_state 0/1 with LFSR-drawn dwell times.
// Optional transition statistics counter enabled by defining RSS_STAT_EN.
module random_state_scheduler #(
  parameter int                 DUR_W      = 16,
  parameter int                 CNT_W      = 32,
  parameter logic [DUR_W-1:0]   DEF_S0_MIN = 100,
  parameter logic [DUR_W-1:0]   DEF_S0_MAX = 600,
  parameter logic [DUR_W-1:0]   DEF_S1_MIN = 60,
  parameter logic [DUR_W-1:0]   DEF_S1_MAX = 500,
  parameter logic [DUR_W-1:0]   LFSR_SEED  = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_a_rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [DUR_W-1:0] i_s0_min,
  input  logic [DUR_W-1:0] i_s0_max,
  input  logic [DUR_W-1:0] i_s1_min,
  input  logic [DUR_W-1:0] i_s1_max,
  input  logic [CNT_W-1:0] i_period_num,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_state,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
`ifdef RSS_STAT_EN
  ,
  output logic [CNT_W-1:0] o_trans_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, S0, S1, DONE} state_t;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form.
  localparam logic [DUR_W-1:0] LFSR_TAPS = 'hB400;
  localparam logic [DUR_W:0]   ONE_D     = 1;
  localparam logic [CNT_W-1:0] ONE_C     = 1;
  localparam int               PW        = 2*DUR_W + 1;

  state_t           r_state, w_nxt;
  logic [DUR_W:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_per, w_per_nxt, w_per_inc;
  logic [DUR_W-1:0] r_lfsr, w_lfsr_nxt;
  logic [DUR_W-1:0] r_s0_min, r_s0_max, r_s1_min, r_s1_max;
  logic [CNT_W-1:0] r_pnum;
  logic             r_err;
  logic             r_rst_done;

  logic             w_busy, w_accept, w_cfg_ok, w_load, w_start_ok;
  logic [DUR_W-1:0] w_s0_min, w_s0_max, w_s1_min, w_s1_max;
  logic [DUR_W:0]   w_rng0, w_rng1, w_ld0, w_ld1;
  logic [PW-1:0]    w_prod0, w_prod1;

  assign w_busy      = (r_state == S0) || (r_state == S1);
  assign o_busy      = w_busy;
  assign o_state     = (r_state == S1);
  assign o_done      = (r_state == DONE);
  assign o_err       = r_err;
  assign o_cfg_ready = r_rst_done && (r_state == IDLE);

  assign w_accept = i_cfg_valid && o_cfg_ready;
  assign w_cfg_ok = (i_s0_min != '0) && (i_s1_min != '0) &&
                    (i_s0_min <= i_s0_max) && (i_s1_min <= i_s1_max);
  assign w_load   = w_accept && w_cfg_ok;

  // A start coinciding with an accept runs on the incoming bounds; a
  // coinciding valid accept also overrides a stale error.
  assign w_start_ok = i_start && (r_state == IDLE) && (w_accept ? w_cfg_ok : !r_err);

  assign w_s0_min = w_load ? i_s0_min : r_s0_min;
  assign w_s0_max = w_load ? i_s0_max : r_s0_max;
  assign w_s1_min = w_load ? i_s1_min : r_s1_min;
  assign w_s1_max = w_load ? i_s1_max : r_s1_max;

  // dur = min + ((lfsr * (max-min+1)) >> DUR_W); counter loads dur-1.
  assign w_rng0  = {1'b0, w_s0_max} - {1'b0, w_s0_min} + ONE_D;
  assign w_rng1  = {1'b0, w_s1_max} - {1'b0, w_s1_min} + ONE_D;
  assign w_prod0 = {{(DUR_W+1){1'b0}}, r_lfsr} * {{DUR_W{1'b0}}, w_rng0};
  assign w_prod1 = {{(DUR_W+1){1'b0}}, r_lfsr} * {{DUR_W{1'b0}}, w_rng1};
  assign w_ld0   = {1'b0, w_s0_min} + w_prod0[PW-1:DUR_W] - ONE_D;
  assign w_ld1   = {1'b0, w_s1_min} + w_prod1[PW-1:DUR_W] - ONE_D;

  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  assign w_per_inc  = r_per + ONE_C;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_per_nxt = r_per;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_nxt     = S0;
          w_cnt_nxt = w_ld0;
          w_per_nxt = '0;
        end
      end
      S0: begin
        if (i_stop) begin
          w_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_nxt     = S1;
          w_cnt_nxt = w_ld1;
        end else begin
          w_cnt_nxt = r_cnt - ONE_D;
        end
      end
      S1: begin
        if (i_stop) begin
          w_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_per_nxt = w_per_inc;
          if ((r_pnum != '0) && (w_per_inc == r_pnum)) begin
            w_nxt = DONE;
          end else begin
            w_nxt     = S0;
            w_cnt_nxt = w_ld0;
          end
        end else begin
          w_cnt_nxt = r_cnt - ONE_D;
        end
      end
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_per      <= '0;
      r_lfsr     <= LFSR_SEED;
      r_err      <= 1'b0;
      r_rst_done <= 1'b0;
      r_s0_min   <= DEF_S0_MIN;
      r_s0_max   <= DEF_S0_MAX;
      r_s1_min   <= DEF_S1_MIN;
      r_s1_max   <= DEF_S1_MAX;
      r_pnum     <= ONE_C;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_per      <= w_per_nxt;
      r_rst_done <= 1'b1;
      if (w_busy)   r_lfsr <= w_lfsr_nxt;
      if (w_accept) r_err  <= !w_cfg_ok;
      if (w_load) begin
        r_s0_min <= i_s0_min;
        r_s0_max <= i_s0_max;
        r_s1_min <= i_s1_min;
        r_s1_max <= i_s1_max;
        r_pnum   <= i_period_num;
      end
    end
  end

`ifdef RSS_STAT_EN
  logic [CNT_W-1:0] r_trans_cnt;
  logic             w_toggle;

  // o_state is a decode of the state register, so its edges are known one cycle early.
  assign w_toggle    = (r_state == S1) != (w_nxt == S1);
  assign o_trans_cnt = r_trans_cnt;

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n)    r_trans_cnt <= '0;
    else if (w_toggle) r_trans_cnt <= r_trans_cnt + ONE_C;
  end
`endif

endmodule
